// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with a latency-matched pixel request port
// and a registered output stage (syncs, strobes, display enable, colour).
`timescale 1ns/1ps

module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   CNT_W    = 11,
    parameter int   COLOR_W  = 4,
    parameter int   OUT_W    = 8,
    parameter int   PIPE_LAT = 1
) (
    input  logic                 pclk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [3*COLOR_W-1:0] color_in,
    output logic                 req,
    output logic [CNT_W-1:0]     h_addr,
    output logic [CNT_W-1:0]     v_addr,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 valid,
    output logic                 line_start,
    output logic                 frame_start,
    output logic [OUT_W-1:0]     vga_r,
    output logic [OUT_W-1:0]     vga_g,
    output logic [OUT_W-1:0]     vga_b
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);

    typedef struct packed {
        logic fs;
        logic ls;
        logic vld;
        logic vs;
        logic hs;
    } ctl_t;

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_act;
    logic             v_act;
    ctl_t             raw;
    ctl_t             load;
    ctl_t             sr [PIPE_LAT+1];

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!enable) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Request contract: while req=1 the source must present the colour for
    // (h_addr, v_addr) on color_in exactly PIPE_LAT cycles after the edge that
    // samples the request; there is no back-pressure.
    always_comb begin
        h_act    = (h_cnt < H_ACT_C);
        v_act    = (v_cnt < V_ACT_C);
        req      = reset_n & enable & h_act & v_act;
        h_addr   = req ? h_cnt : '0;
        v_addr   = req ? v_cnt : '0;
        raw.hs   = enable & (h_cnt >= HS_BEG) & (h_cnt < HS_END);
        raw.vs   = enable & (v_cnt >= VS_BEG) & (v_cnt < VS_END);
        raw.vld  = enable & h_act & v_act;
        raw.ls   = enable & (h_cnt == '0) & v_act;
        raw.fs   = enable & (h_cnt == '0) & (v_cnt == '0);
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i <= PIPE_LAT; i++) sr[i] <= '0;
        end else begin
            sr[0] <= raw;
            for (int i = 1; i <= PIPE_LAT; i++) sr[i] <= sr[i-1];
        end
    end

    // The colour register loads on the same edge the control bits reach the
    // last stage, so it looks one stage back to decide whether to sample.
    if (PIPE_LAT == 0) begin : g_load_raw
        assign load = raw;
    end else begin : g_load_sr
        assign load = sr[PIPE_LAT-1];
    end

    function automatic logic [OUT_W-1:0] expand(input logic [COLOR_W-1:0] c);
        logic [OUT_W-1:0] res;
        res = '0;
        for (int i = 0; i < OUT_W; i++) res[OUT_W-1-i] = c[COLOR_W-1-(i % COLOR_W)];
        return res;
    endfunction

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            vga_r <= '0;
            vga_g <= '0;
            vga_b <= '0;
        end else if (load.vld) begin
            vga_r <= expand(color_in[3*COLOR_W-1 -: COLOR_W]);
            vga_g <= expand(color_in[2*COLOR_W-1 -: COLOR_W]);
            vga_b <= expand(color_in[COLOR_W-1:0]);
        end else begin
            vga_r <= '0;
            vga_g <= '0;
            vga_b <= '0;
        end
    end

    assign hsync       = sr[PIPE_LAT].hs ? HS_POL : ~HS_POL;
    assign vsync       = sr[PIPE_LAT].vs ? VS_POL : ~VS_POL;
    assign valid       = sr[PIPE_LAT].vld;
    assign line_start  = sr[PIPE_LAT].ls;
    assign frame_start = sr[PIPE_LAT].fs;

endmodule
